// File: rtl/de1_blinker_oci_pkg.sv
// rtl/de1_blinker_oci_pkg.sv - shared state encoding and default sizing for the OCI trace capture
package de1_blinker_oci_pkg;

    localparam int OCI_DATA_W = 30;
    localparam int OCI_CNT_W  = 4;
    localparam int OCI_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/de1_blinker_oci_trace_fifo.sv
// rtl/de1_blinker_oci_trace_fifo.sv - first-word fall-through trace storage with optional overwrite-oldest
module de1_blinker_oci_trace_fifo
    import de1_blinker_oci_pkg::*;
#(
    parameter int WIDTH = OCI_CNT_W + OCI_DATA_W,
    parameter int DEPTH = OCI_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     wrap_mode,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     lost
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    logic is_full;
    logic do_pop;
    logic do_write;
    logic overwrite;

    // A pop only counts when something is stored; a full write either steals the oldest slot or is lost.
    always_comb begin
        is_full   = (count == LVL_W'(DEPTH));
        do_pop    = pop && (count != '0);
        overwrite = push && is_full && !do_pop && wrap_mode;
        do_write  = push && (!is_full || do_pop || wrap_mode);
        lost      = push && is_full && !do_pop;
    end

    assign rdata = mem[rd_ptr];
    assign level = count;

    // Pointers wrap naturally at the power-of-two depth; clear restarts an empty buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !is_full && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage array carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_write && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/de1_blinker_nios2_proc_oci_trace_capture.sv
// rtl/de1_blinker_nios2_proc_oci_trace_capture.sv - session FSM and frame qualification around the trace FIFO
module de1_blinker_nios2_proc_oci_trace_capture
    import de1_blinker_oci_pkg::*;
#(
    parameter int DATA_W = OCI_DATA_W,
    parameter int CNT_W  = OCI_CNT_W,
    parameter int DEPTH  = OCI_DEPTH,
    parameter int WRAP   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     arm,
    input  logic                     dct_valid,
    input  logic [DATA_W-1:0]        dct_buffer,
    input  logic [CNT_W-1:0]         dct_count,
    input  logic                     test_ending,
    input  logic                     test_has_ended,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [CNT_W+DATA_W-1:0]  rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     capture_done
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    cap_state_t state;
    cap_state_t state_nxt;

    logic             arm_ok;
    logic             clear;
    logic             push;
    logic             pop;
    logic             fifo_lost;
    logic [LVL_W-1:0] fifo_level;

    // Arm is only honoured between sessions; abort always wins and wipes the buffer.
    always_comb begin
        arm_ok   = arm && ((state == ST_IDLE) || (state == ST_DONE));
        clear    = test_has_ended || arm_ok;
        push     = (state == ST_CAPTURE) && dct_valid && (dct_count != '0)
                   && !test_ending && !test_has_ended;
        rd_valid = (state != ST_IDLE) && (fifo_level != '0);
        pop      = rd_valid && rd_ready && !test_has_ended;
    end

    de1_blinker_oci_trace_fifo #(
        .WIDTH (CNT_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .wrap_mode (WRAP != 0),
        .wdata     ({dct_count, dct_buffer}),
        .rdata     (rd_data),
        .level     (fifo_level),
        .lost      (fifo_lost)
    );

    // Session sequencing; drain finishes on the edge that empties the buffer.
    always_comb begin
        state_nxt = state;
        if (test_has_ended) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) state_nxt = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (test_ending) state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((fifo_level == '0) || ((fifo_level == LVL_W'(1)) && pop)) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (arm) state_nxt = ST_CAPTURE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky loss flag, reset with each new session or abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (fifo_lost) begin
            overflow <= 1'b1;
        end
    end

    assign level        = fifo_level;
    assign capture_done = (state == ST_DONE);

endmodule

// File: tb/tb_de1_blinker_nios2_proc_oci_trace_capture.sv
// tb/tb_de1_blinker_nios2_proc_oci_trace_capture.sv - scoreboard bench for stop-on-full and overwrite capture
module tb_de1_blinker_nios2_proc_oci_trace_capture;

    localparam int DW = 30;
    localparam int CW = 4;
    localparam int D  = 4;
    localparam int RW = CW + DW;

    localparam int S_IDLE  = 0;
    localparam int S_CAP   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          arm = 1'b0;
    logic          dct_valid = 1'b0;
    logic [DW-1:0] dct_buffer = '0;
    logic [CW-1:0] dct_count = '0;
    logic          test_ending = 1'b0;
    logic          test_has_ended = 1'b0;
    logic          rd_ready = 1'b0;

    logic          rd_valid_o [2];
    logic [RW-1:0] rd_data_o  [2];
    logic [2:0]    level_o    [2];
    logic          overflow_o [2];
    logic          done_o     [2];

    int n_vec = 0;
    int n_bad = 0;

    int            m_st  [2];
    int            m_lvl [2];
    bit            m_ovf [2];
    logic [RW-1:0] exp_q [2][$];

    always #5 clk = ~clk;

    de1_blinker_nios2_proc_oci_trace_capture #(
        .DATA_W(DW), .CNT_W(CW), .DEPTH(D), .WRAP(0)
    ) dut_stop (
        .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .rd_ready(rd_ready),
        .rd_valid(rd_valid_o[0]), .rd_data(rd_data_o[0]), .level(level_o[0]),
        .overflow(overflow_o[0]), .capture_done(done_o[0])
    );

    de1_blinker_nios2_proc_oci_trace_capture #(
        .DATA_W(DW), .CNT_W(CW), .DEPTH(D), .WRAP(1)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .rd_ready(rd_ready),
        .rd_valid(rd_valid_o[1]), .rd_data(rd_data_o[1]), .level(level_o[1]),
        .overflow(overflow_o[1]), .capture_done(done_o[1])
    );

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s wrap=%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic m_clear(input int i);
        exp_q[i].delete();
        m_lvl[i] = 0;
        m_ovf[i] = 1'b0;
    endtask

    // Buffer behaviour: in-order queue of at most D entries; a full write is lost or evicts the oldest.
    task automatic m_apply(input int i, input bit pop, input bit wr, input logic [RW-1:0] d);
        if (wr) begin
            if (m_lvl[i] < D || pop) begin
                exp_q[i].push_back(d);
                if (!pop) m_lvl[i]++;
            end else begin
                m_ovf[i] = 1'b1;
                if (i == 1) begin
                    exp_q[i].delete(0);
                    exp_q[i].push_back(d);
                end
            end
        end else if (pop) begin
            m_lvl[i]--;
        end
    endtask

    task automatic m_step(input int i);
        bit pop;
        bit wr;
        pop = (m_st[i] != S_IDLE) && (m_lvl[i] > 0) && rd_ready;
        if (test_has_ended) begin
            m_clear(i);
            m_st[i] = S_IDLE;
        end else begin
            case (m_st[i])
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        m_clear(i);
                        m_st[i] = S_CAP;
                    end
                end
                S_CAP: begin
                    wr = !test_ending && dct_valid && (dct_count != 0);
                    m_apply(i, pop, wr, {dct_count, dct_buffer});
                    if (test_ending) m_st[i] = S_DRAIN;
                end
                default: begin
                    m_apply(i, pop, 1'b0, '0);
                    if (m_lvl[i] == 0) m_st[i] = S_DONE;
                end
            endcase
        end
    endtask

    // Reference model advances on the same edges as the designs.
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_clear(i);
                m_st[i] = S_IDLE;
            end else begin
                m_step(i);
            end
        end
    end

    // Monitor: compare status every cycle and pop the scoreboard whenever a read is accepted.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("level", i, 64'(level_o[i]), 64'(m_lvl[i]));
            chk("rd_valid", i, 64'(rd_valid_o[i]), 64'((m_st[i] != S_IDLE) && (m_lvl[i] != 0)));
            chk("overflow", i, 64'(overflow_o[i]), 64'(m_ovf[i]));
            chk("capture_done", i, 64'(done_o[i]), 64'(m_st[i] == S_DONE));
            if (rd_valid_o[i] === 1'b1 && rd_ready) begin
                if (exp_q[i].size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL rd_data wrap=%0d: got %0h expected none (scoreboard empty) at %0t",
                             i, rd_data_o[i], $time);
                end else begin
                    chk("rd_data", i, 64'(rd_data_o[i]), 64'(exp_q[i].pop_front()));
                end
            end
        end
    end

    task automatic cyc(input bit a, input bit v, input logic [DW-1:0] b, input logic [CW-1:0] c,
                       input bit te, input bit th, input bit rr);
        arm            = a;
        dct_valid      = v;
        dct_buffer     = b;
        dct_count      = c;
        test_ending    = te;
        test_has_ended = th;
        rd_ready       = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int k = 0; k < n; k++) cyc(0, 0, '0, '0, 0, 0, rr);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2, 1);

        // three-frame capture then drain
        cyc(1, 0, '0, '0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) cyc(0, 1, DW'(k), CW'(k), 0, 0, 0);
        cyc(0, 0, '0, '0, 1, 0, 0);
        idle(5, 1);

        // six writes into a depth-4 buffer, then drain
        cyc(1, 0, '0, '0, 0, 0, 0);
        for (int k = 0; k < 6; k++) cyc(0, 1, DW'(k), 4'd1, 0, 0, 0);
        idle(1, 0);
        cyc(0, 0, '0, '0, 1, 0, 0);
        idle(6, 1);

        // simultaneous push and pop while full
        cyc(1, 0, '0, '0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, DW'(k + 20), 4'd2, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, DW'(k + 30), 4'd3, 0, 0, 1);
        cyc(0, 0, '0, '0, 1, 0, 0);
        idle(6, 1);

        // zero-count frame, then a write colliding with test_ending
        cyc(1, 0, '0, '0, 0, 0, 0);
        cyc(0, 1, DW'(7), 4'd0, 0, 0, 0);
        cyc(0, 1, DW'(8), 4'd1, 0, 0, 0);
        cyc(0, 1, DW'(9), 4'd2, 1, 0, 0);
        idle(4, 1);

        // abort mid-drain with two entries left
        cyc(1, 0, '0, '0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, DW'(k + 40), 4'd5, 0, 0, 0);
        cyc(0, 0, '0, '0, 1, 0, 0);
        idle(2, 1);
        cyc(0, 0, '0, '0, 0, 1, 0);
        idle(2, 1);

        // reset pulse mid-capture
        cyc(1, 0, '0, '0, 0, 0, 0);
        cyc(0, 1, DW'(50), 4'd6, 0, 0, 0);
        cyc(0, 1, DW'(51), 4'd7, 0, 0, 0);
        reset_n = 1'b0;
        idle(2, 0);
        reset_n = 1'b1;
        idle(2, 1);

        // randomized sessions with varying consumer pressure
        for (int blk = 0; blk < 15; blk++) begin
            int thr;
            thr = $urandom_range(0, 4);
            for (int k = 0; k < 200; k++) begin
                reset_n = ($urandom % 400) != 0;
                cyc(($urandom % 12) == 0, $urandom % 2, DW'($urandom), CW'($urandom),
                    ($urandom % 24) == 0, ($urandom % 150) == 0, ($urandom % 4) < thr);
            end
        end
        reset_n = 1'b1;
        idle(3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/de1_blinker_nios2_proc_oci_trace_capture.md
DE1_BLINKER_NIOS2_PROC_OCI_TRACE_CAPTURE -- requirements
Module: de1_blinker_nios2_proc_oci_trace_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 30: width of the DCT data word.
REQ-002 SHALL have parameter CNT_W, default 4: width of the DCT count field.
REQ-003 SHALL have parameter DEPTH, default 16: number of capture entries; power of two, minimum 2.
REQ-004 SHALL have parameter WRAP, default 0: 0 = stop-on-full; 1 = overwrite oldest entry.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port arm, input, 1: start a new capture session.
REQ-008 SHALL have port dct_valid, input, 1: dct_buffer/dct_count are valid this cycle.
REQ-009 SHALL have port dct_buffer, input, DATA_W: DCT data word.
REQ-010 SHALL have port dct_count, input, CNT_W: DCT frame count.
REQ-011 SHALL have port test_ending, input, 1: stop capturing and start drain.
REQ-012 SHALL have port test_has_ended, input, 1: abort; discard contents.
REQ-013 SHALL have port rd_ready, input, 1: consumer accepts rd_data.
REQ-014 SHALL have port rd_valid, output, 1: an entry is available.
REQ-015 SHALL have port rd_data, output, CNT_W+DATA_W: {count, data} of the oldest entry.
REQ-016 SHALL have port level, output, clog2(DEPTH)+1: current occupancy.
REQ-017 SHALL have port overflow, output, 1: sticky; one or more entries lost or overwritten.
REQ-018 SHALL have port capture_done, output, 1: high in state DONE.

Function
REQ-019 SHALL implement FSM states IDLE, CAPTURE, DRAIN, DONE.
REQ-020 SHALL transition IDLE->CAPTURE and DONE->CAPTURE on arm; arm SHALL clear the buffer, level and overflow in the same edge; arm in CAPTURE/DRAIN SHALL be ignored.
REQ-021 SHALL transition CAPTURE->DRAIN on test_ending; test_ending SHALL take priority over a same-cycle write, which is dropped without setting overflow.
REQ-022 SHALL transition DRAIN->DONE on the edge where level becomes 0, or immediately if level is already 0.
REQ-023 SHALL transition any non-IDLE state->IDLE on test_has_ended, clearing the buffer, level and overflow; test_has_ended SHALL take priority over arm and test_ending.
REQ-024 SHALL write an entry only in CAPTURE, with dct_valid=1 and dct_count!=0; frames with a zero count SHALL be dropped silently.
REQ-025 SHALL make the entry visible as rd_valid=1 one cycle after the write edge (first-word fall-through; rd_data combinational from storage).
REQ-026 SHALL assert rd_valid = (level!=0) in CAPTURE, DRAIN and DONE, and force it to 0 in IDLE; a pop occurs when rd_valid and rd_ready are both high.
REQ-027 When WRAP=0 and full, a write without a same-cycle pop SHALL be dropped and SHALL set overflow.
REQ-028 When WRAP=1 and full, a write without a same-cycle pop SHALL overwrite the oldest entry, advance the read pointer, keep level=DEPTH and set overflow.
REQ-029 With a simultaneous push and pop, level SHALL be unchanged, no overflow SHALL be flagged, and both events SHALL take effect, including when full or when level=1.
REQ-030 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-031 On reset_n=0, state SHALL be IDLE and level, rd_valid, overflow and capture_done SHALL be 0, asynchronously.
REQ-032 Storage contents SHALL need no reset; rd_data SHALL be don't-care while rd_valid=0.
REQ-033 Deassertion of reset_n SHALL be synchronised externally; reset SHALL abort any operation in progress.

Structure
REQ-034 A shared package de1_blinker_oci_pkg SHALL hold the state enumeration and the default width/depth constants.
REQ-035 Storage and pointers SHALL be in one sub-module, de1_blinker_oci_trace_fifo, which has push, pop, wrap-mode and clear inputs; the top level holds the FSM and qualification logic.

Verification
REQ-036 Scenario: arm, then 3 frames (count 1,2,3; data 0x1,0x2,0x3), test_ending, rd_ready=1 -> rd_data sequence {1,0x1},{2,0x2},{3,0x3}; capture_done rises on the cycle after the last pop.
REQ-037 Scenario: WRAP=0, DEPTH=4, 6 writes (data 0..5) with rd_ready=0 -> level=4, overflow=1; drain yields data 0,1,2,3.
REQ-038 Scenario: WRAP=1, DEPTH=4, 6 writes (data 0..5) with rd_ready=0 -> level=4, overflow=1; drain yields data 2,3,4,5.
REQ-039 Scenario: DEPTH=4, buffer full, push and pop in the same cycle with WRAP=0 and then WRAP=1 -> level stays 4, overflow stays 0, FIFO order is preserved.
REQ-040 Scenario: dct_count=0 with dct_valid=1; and test_ending coincident with a write -> level unchanged in both cases, overflow=0.
REQ-041 Scenario: test_has_ended mid-DRAIN with level=2; and reset_n pulsed low mid-CAPTURE -> state IDLE, level=0, rd_valid=0 in both cases.
